reg_bus_sequencer: RTL and testbench
====================================

REG_BUS_SEQUENCER -- requirements
Module: reg_bus_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, data width of bus, registers and immediate.
REQ-002 Parameter NUM_REGS, default 4, number of general registers on the shared bus (2..16).
REQ-003 Parameter IDX_W, default $clog2(NUM_REGS), width of register index fields.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  input  1  command presented.
REQ-007 cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-008 cmd_op  input  2  opcode: MOV=0, LDI=1, OUT=2, NOP=3.
REQ-009 cmd_src  input  IDX_W  source register index (MOV, OUT).
REQ-010 cmd_dst  input  IDX_W  destination register index (MOV, LDI).
REQ-011 cmd_imm  input  WIDTH  immediate value (LDI).
REQ-012 bus  output  WIDTH  current shared-bus value.
REQ-013 out_val  output  WIDTH  held output register.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse on successful command completion.
REQ-016 err  output  1  one-cycle pulse on rejected command.

Function
REQ-017 FSM states: IDLE, DRIVE, LATCH, DONE; cmd_ready = (state==IDLE).
REQ-018 Handshake: command captured into internal op/src/dst/imm registers when cmd_valid && cmd_ready; inputs ignored otherwise.
REQ-019 IDLE -> DRIVE on accept of a valid command; IDLE -> IDLE with err pulse next cycle if any used index >= NUM_REGS; NOP -> DONE directly.
REQ-020 DRIVE: bus driven by source (register[src] for MOV/OUT, captured imm for LDI); no register loads; -> LATCH.
REQ-021 LATCH: bus still driven; destination (register[dst] for MOV/LDI, out_val for OUT) loads bus at the closing edge; -> DONE.
REQ-022 DONE: bus = 0, done=1 for exactly this cycle; -> IDLE.
REQ-023 Latency: accept at edge t, destination updated at edge t+2, done high during cycle t+3 (t+1 for NOP), next accept possible at edge t+4.
REQ-024 Bus equals 0 whenever no source is enabled (IDLE, DONE); exactly one source enabled at a time.
REQ-025 Only one register load per command; all other registers and out_val hold.
REQ-026 MOV with src==dst is legal; register value unchanged; done pulses.
REQ-027 err and done never assert in the same cycle; err does not alter any register or out_val.
REQ-028 Indices >= NUM_REGS in fields unused by the opcode are ignored (no err).

Reset
REQ-029 Reset forces state=IDLE, all registers=0, out_val=0, captured command=0, bus=0, busy=0, done=0, err=0, cmd_ready=1 after deassertion.
REQ-030 Reset mid-command aborts it: no destination load, no done pulse.

Structure
REQ-031 Shared package holds opcode localparams (OP_MOV, OP_LDI, OP_OUT, OP_NOP) and the FSM state encoding.
REQ-032 Register bank built from NUM_REGS instances of existing register_nbit (N=WIDTH) plus one for out_val; bus mux and FSM in this module.

Verification
REQ-033 Reset, then LDI dst=0 imm=0xA5 -> reg0=0xA5 at edge t+2, done in cycle t+3, bus=0xA5 in DRIVE/LATCH.
REQ-034 LDI r1=0x3C; MOV src=1 dst=2; OUT src=2 -> out_val=0x3C, r1 unchanged, three done pulses.
REQ-035 cmd_valid held high continuously with back-to-back commands -> one accept per 4 cycles, cmd_ready low in DRIVE/LATCH/DONE.
REQ-036 NUM_REGS=3, MOV src=3 dst=0 -> err pulse, no done, reg0 unchanged; then OUT src=0 with dst=3 -> done, no err.
REQ-037 Assert reset during LATCH of LDI r0=0xFF -> reg0=0, no done, out_val=0, cmd_ready=1 after release.
REQ-038 Run WIDTH=16, NUM_REGS=8: LDI r7=0xBEEF; OUT src=7 -> out_val=0xBEEF.

Source files
------------

// File: rtl/reg_bus_sequencer_pkg.sv
// Shared opcode and FSM state encodings for the register-bus sequencer.
package reg_bus_sequencer_pkg;

    localparam int unsigned OP_W    = 2;
    localparam int unsigned STATE_W = 2;

    localparam logic [OP_W-1:0] OP_MOV = 2'd0;
    localparam logic [OP_W-1:0] OP_LDI = 2'd1;
    localparam logic [OP_W-1:0] OP_OUT = 2'd2;
    localparam logic [OP_W-1:0] OP_NOP = 2'd3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_DRIVE = 2'd1;
    localparam logic [STATE_W-1:0] ST_LATCH = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

    function automatic logic op_uses_src(input logic [OP_W-1:0] op);
        return (op == OP_MOV) || (op == OP_OUT);
    endfunction

    function automatic logic op_uses_dst(input logic [OP_W-1:0] op);
        return (op == OP_MOV) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/register_nbit.sv
// N-bit load-enabled register with asynchronous active-high clear.
module register_nbit #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_bus_sequencer.sv
// Sequences MOV/LDI/OUT/NOP commands over a single shared bus feeding a
// register bank and a held output register.
module reg_bus_sequencer
    import reg_bus_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [IDX_W-1:0] cmd_src,
    input  logic [IDX_W-1:0] cmd_dst,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] out_val,
    output logic             busy,
    output logic             done,
    output logic             err
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_next;
    logic               err_q;
    logic               err_next;

    logic [OP_W-1:0]    op_q;
    logic [IDX_W-1:0]   src_q;
    logic [IDX_W-1:0]   dst_q;
    logic [WIDTH-1:0]   imm_q;

    logic               accept_c;
    logic               bad_c;
    logic [WIDTH-1:0]   src_val;
    logic [NUM_REGS-1:0] reg_load;
    logic               out_load;
    logic [WIDTH-1:0]   reg_q [NUM_REGS];

    assign accept_c = cmd_valid && cmd_ready;

    // Only index fields the opcode actually uses can cause a rejection.
    assign bad_c = (op_uses_src(cmd_op) && (32'(cmd_src) >= NUM_REGS)) ||
                   (op_uses_dst(cmd_op) && (32'(cmd_dst) >= NUM_REGS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_next;
            err_q   <= err_next;
        end
    end

    always_comb begin
        state_next = state_q;
        err_next   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (bad_c) begin
                        err_next = 1'b1;
                    end else if (cmd_op == OP_NOP) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: state_next = ST_LATCH;
            ST_LATCH: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= '0;
            src_q <= '0;
            dst_q <= '0;
            imm_q <= '0;
        end else if (accept_c) begin
            op_q  <= cmd_op;
            src_q <= cmd_src;
            dst_q <= cmd_dst;
            imm_q <= cmd_imm;
        end
    end

    // Single bus source: immediate for LDI, otherwise the selected register.
    always_comb begin
        src_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (src_q == IDX_W'(i)) begin
                src_val = reg_q[i];
            end
        end
        if ((state_q == ST_DRIVE) || (state_q == ST_LATCH)) begin
            bus = (op_q == OP_LDI) ? imm_q : src_val;
        end else begin
            bus = '0;
        end
    end

    always_comb begin
        reg_load = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_load[i] = (state_q == ST_LATCH) && op_uses_dst(op_q) &&
                          (dst_q == IDX_W'(i));
        end
        out_load = (state_q == ST_LATCH) && (op_q == OP_OUT);
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        register_nbit #(.N(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .load  (reg_load[g]),
            .d     (bus),
            .q     (reg_q[g])
        );
    end

    register_nbit #(.N(WIDTH)) u_out (
        .clk   (clk),
        .reset (reset),
        .load  (out_load),
        .d     (bus),
        .q     (out_val)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Scoreboard bench for reg_bus_sequencer across three parameter sets.
module tb_reg_bus_sequencer;

    localparam int PERIOD = 10;

    typedef struct {
        int          dut;
        bit          is_err;
        bit          has_bus;
        logic [15:0] bus;
        logic [15:0] out;
    } exp_t;

    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  vld;
    logic [1:0]  op;
    logic [2:0]  src;
    logic [2:0]  dst;
    logic [15:0] imm;

    logic [2:0]  ready_m, busy_m, done_m, err_m;
    logic [7:0]  bus_a, out_a, bus_b, out_b;
    logic [15:0] bus_c, out_c;
    logic [15:0] bus_m [3];
    logic [15:0] out_m [3];

    exp_t        sb[$];
    int          checks;
    int          failures;
    int          bcnt [3];
    logic [15:0] bsee [3][2];
    longint      acc_time;

    reg_bus_sequencer #(.WIDTH(8), .NUM_REGS(4)) u_a (
        .clk(clk), .reset(rst[0]), .cmd_valid(vld[0]), .cmd_ready(ready_m[0]),
        .cmd_op(op), .cmd_src(src[1:0]), .cmd_dst(dst[1:0]), .cmd_imm(imm[7:0]),
        .bus(bus_a), .out_val(out_a), .busy(busy_m[0]), .done(done_m[0]), .err(err_m[0])
    );

    reg_bus_sequencer #(.WIDTH(8), .NUM_REGS(3)) u_b (
        .clk(clk), .reset(rst[1]), .cmd_valid(vld[1]), .cmd_ready(ready_m[1]),
        .cmd_op(op), .cmd_src(src[1:0]), .cmd_dst(dst[1:0]), .cmd_imm(imm[7:0]),
        .bus(bus_b), .out_val(out_b), .busy(busy_m[1]), .done(done_m[1]), .err(err_m[1])
    );

    reg_bus_sequencer #(.WIDTH(16), .NUM_REGS(8)) u_c (
        .clk(clk), .reset(rst[2]), .cmd_valid(vld[2]), .cmd_ready(ready_m[2]),
        .cmd_op(op), .cmd_src(src), .cmd_dst(dst), .cmd_imm(imm),
        .bus(bus_c), .out_val(out_c), .busy(busy_m[2]), .done(done_m[2]), .err(err_m[2])
    );

    always_comb begin
        bus_m[0] = 16'(bus_a);
        bus_m[1] = 16'(bus_b);
        bus_m[2] = bus_c;
        out_m[0] = 16'(out_a);
        out_m[1] = 16'(out_b);
        out_m[2] = out_c;
    end

    initial clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    task automatic chk(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d actual=%h required=%h", nm, d, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done/err pulse and checks bus history.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                bcnt[i] = 0;
            end else begin
                if (busy_m[i] && !done_m[i]) begin
                    if (bcnt[i] < 2) bsee[i][bcnt[i]] = bus_m[i];
                    bcnt[i]++;
                end else begin
                    chk("bus_zero", i, 32'(bus_m[i]), 32'h0);
                end
                if (done_m[i] && err_m[i]) begin
                    chk("done_err_overlap", i, 32'(done_m[i] && err_m[i]), 32'h0);
                end else if (done_m[i] || err_m[i]) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_resp", i, {30'h0, err_m[i], done_m[i]}, 32'h0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("resp_dut", i, 32'(i), 32'(e.dut));
                        chk("resp_kind_err", i, 32'(err_m[i]), 32'(e.is_err));
                        if (done_m[i]) begin
                            chk("out_val", i, 32'(out_m[i]), 32'(e.out));
                            chk("bus_cycles", i, 32'(bcnt[i]), e.has_bus ? 32'd2 : 32'd0);
                            if (e.has_bus && bcnt[i] == 2) begin
                                chk("bus_drive", i, 32'(bsee[i][0]), 32'(e.bus));
                                chk("bus_latch", i, 32'(bsee[i][1]), 32'(e.bus));
                            end
                        end
                    end
                    bcnt[i] = 0;
                end
            end
        end
    end

    task automatic issue(input int d, input logic [1:0] o, input logic [2:0] s,
                         input logic [2:0] t, input logic [15:0] v, input bit is_err,
                         input logic [15:0] eb, input logic [15:0] eo, input bit hold);
        exp_t e;
        int   n;
        e.dut     = d;
        e.is_err  = is_err;
        e.has_bus = !is_err && (o != 2'd3);
        e.bus     = eb;
        e.out     = eo;
        sb.push_back(e);
        @(negedge clk);
        op = o; src = s; dst = t; imm = v; vld[d] = 1'b1;
        n = 0;
        while (!ready_m[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", d, 32'(n), 32'd0);
        @(posedge clk);
        acc_time = longint'($time);
        if (!hold) begin
            #1 vld[d] = 1'b0;
        end
    endtask

    task automatic drain(input int d);
        repeat (8) @(negedge clk);
        chk("sb_drain", d, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        longint t0, t1, t2;
        checks = 0; failures = 0;
        rst = 3'b111; vld = 3'b000; op = 2'd0; src = 3'd0; dst = 3'd0; imm = 16'h0;
        repeat (3) @(negedge clk);
        rst = 3'b000;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", i, 32'(ready_m[i]), 32'd1);
            chk("rst_busy", i, 32'(busy_m[i]), 32'd0);
            chk("rst_done", i, 32'(done_m[i]), 32'd0);
            chk("rst_err", i, 32'(err_m[i]), 32'd0);
            chk("rst_bus", i, 32'(bus_m[i]), 32'd0);
            chk("rst_out", i, 32'(out_m[i]), 32'd0);
        end

        // Default config: LDI/MOV/OUT/NOP flow
        issue(0, 2'd1, 3'd0, 3'd0, 16'h00A5, 0, 16'h00A5, 16'h0000, 0);
        issue(0, 2'd2, 3'd0, 3'd0, 16'h0000, 0, 16'h00A5, 16'h00A5, 0);
        issue(0, 2'd1, 3'd0, 3'd1, 16'h003C, 0, 16'h003C, 16'h00A5, 0);
        issue(0, 2'd0, 3'd1, 3'd2, 16'h0000, 0, 16'h003C, 16'h00A5, 0);
        issue(0, 2'd2, 3'd2, 3'd0, 16'h0000, 0, 16'h003C, 16'h003C, 0);
        issue(0, 2'd2, 3'd0, 3'd0, 16'h0000, 0, 16'h00A5, 16'h00A5, 0);
        issue(0, 2'd2, 3'd1, 3'd0, 16'h0000, 0, 16'h003C, 16'h003C, 0);
        issue(0, 2'd0, 3'd2, 3'd2, 16'h0000, 0, 16'h003C, 16'h003C, 0);
        issue(0, 2'd2, 3'd0, 3'd0, 16'h0000, 0, 16'h00A5, 16'h00A5, 0);
        issue(0, 2'd2, 3'd2, 3'd0, 16'h0000, 0, 16'h003C, 16'h003C, 0);
        issue(0, 2'd3, 3'd3, 3'd3, 16'h00FF, 0, 16'h0000, 16'h003C, 0);
        drain(0);

        // Back-to-back with cmd_valid held high
        issue(0, 2'd1, 3'd0, 3'd3, 16'h0011, 0, 16'h0011, 16'h003C, 1);
        t0 = acc_time;
        issue(0, 2'd1, 3'd0, 3'd2, 16'h0022, 0, 16'h0022, 16'h003C, 1);
        t1 = acc_time;
        issue(0, 2'd2, 3'd3, 3'd0, 16'h0000, 0, 16'h0011, 16'h0011, 0);
        t2 = acc_time;
        chk("b2b_gap1", 0, 32'(t1 - t0), 32'(4 * PERIOD));
        chk("b2b_gap2", 0, 32'(t2 - t1), 32'(4 * PERIOD));
        issue(0, 2'd2, 3'd2, 3'd0, 16'h0000, 0, 16'h0022, 16'h0022, 0);
        drain(0);

        // Reset during LATCH of LDI r0=0xFF: aborted, no done
        @(negedge clk);
        op = 2'd1; src = 3'd0; dst = 3'd0; imm = 16'h00FF; vld[0] = 1'b1;
        @(posedge clk);
        #1 vld[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        @(negedge clk);
        chk("abort_ready", 0, 32'(ready_m[0]), 32'd1);
        chk("abort_busy", 0, 32'(busy_m[0]), 32'd0);
        chk("abort_out", 0, 32'(out_m[0]), 32'd0);
        issue(0, 2'd2, 3'd0, 3'd0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        issue(0, 2'd2, 3'd2, 3'd0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        drain(0);

        // NUM_REGS=3: out-of-range indices
        issue(1, 2'd1, 3'd0, 3'd0, 16'h005A, 0, 16'h005A, 16'h0000, 0);
        issue(1, 2'd0, 3'd3, 3'd0, 16'h0000, 1, 16'h0000, 16'h0000, 0);
        issue(1, 2'd2, 3'd0, 3'd3, 16'h0000, 0, 16'h005A, 16'h005A, 0);
        issue(1, 2'd1, 3'd0, 3'd3, 16'h0077, 1, 16'h0000, 16'h0000, 0);
        issue(1, 2'd3, 3'd3, 3'd3, 16'h0000, 0, 16'h0000, 16'h005A, 0);
        issue(1, 2'd1, 3'd3, 3'd2, 16'h0066, 0, 16'h0066, 16'h005A, 0);
        issue(1, 2'd2, 3'd2, 3'd3, 16'h0000, 0, 16'h0066, 16'h0066, 0);
        drain(1);

        // WIDTH=16, NUM_REGS=8
        issue(2, 2'd1, 3'd0, 3'd7, 16'hBEEF, 0, 16'hBEEF, 16'h0000, 0);
        issue(2, 2'd2, 3'd7, 3'd0, 16'h0000, 0, 16'hBEEF, 16'hBEEF, 0);
        drain(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
